// File: rtl/serial_pattern_tx.sv
// Word serializer (MSB first) with a golden pattern-match flag and per-word match count,
// used as the reference source for a serial pattern detector.
module serial_pattern_tx #(
  parameter int               DATA_W  = 32,
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b110,
  parameter int               GAP_CYC = 0,
  parameter int               CNT_W   = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_a,
  output logic              o_a_valid,
  output logic              o_last,
  output logic              o_exp_match,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_match_cnt
);

  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int FILL_W = $clog2(PAT_W);
  localparam int HIST_W = PAT_W - 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
  localparam bit                HAS_GAP   = (GAP_CYC > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   shreg_reg, shreg_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [GAP_W-1:0]    gap_reg, gap_next;
  logic [HIST_W-1:0]   hist_reg, hist_next;
  logic [FILL_W-1:0]   fill_reg, fill_next;
  logic [CNT_W-1:0]    run_cnt_reg, run_cnt_next;
  logic [CNT_W-1:0]    match_cnt_reg, match_cnt_next;
  logic                done_reg, done_next;

  logic                a_valid;
  logic                a_bit;
  logic                last_bit;
  logic                exp_match;
  logic                ready;
  logic                accept;
  logic [PAT_W-1:0]    window;

  // Everything visible on the outputs is derived from registers only.
  always_comb begin
    a_valid   = (state_reg == SHIFT);
    a_bit     = a_valid & shreg_reg[DATA_W-1];
    last_bit  = a_valid && (idx_reg == '0);
    window    = {hist_reg, a_bit};
    exp_match = a_valid && (fill_reg == FILL_FULL) && (window == PATTERN);
    ready     = (state_reg == IDLE) || (last_bit && !HAS_GAP);
    accept    = i_valid && ready;
  end

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    idx_next   = idx_reg;
    gap_next   = gap_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          shreg_next = i_data;
          idx_next   = IDX_LAST;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shreg_next = shreg_reg << 1;
        idx_next   = idx_reg - IDX_W'(1);
        if (last_bit) begin
          if (HAS_GAP) begin
            gap_next   = GAP_LOAD;
            state_next = GAP;
          end else if (accept) begin
            // Zero-bubble reload: next word's MSB follows this LSB directly.
            shreg_next = i_data;
            idx_next   = IDX_LAST;
            state_next = SHIFT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_reg == '0) begin
          state_next = IDLE;
        end else begin
          gap_next = gap_reg - GAP_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // History spans word boundaries and gaps; it advances only on emitted bits.
  always_comb begin
    hist_next = hist_reg;
    fill_next = fill_reg;
    if (a_valid) begin
      hist_next = window[HIST_W-1:0];
      if (fill_reg != FILL_FULL) begin
        fill_next = fill_reg + FILL_W'(1);
      end
    end
  end

  always_comb begin
    run_cnt_next   = run_cnt_reg;
    match_cnt_next = match_cnt_reg;
    done_next      = 1'b0;
    if (last_bit) begin
      // A match on the LSB still belongs to the finishing word.
      match_cnt_next = run_cnt_reg + CNT_W'(exp_match);
      run_cnt_next   = '0;
      done_next      = 1'b1;
    end else if (exp_match) begin
      run_cnt_next = run_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      shreg_reg     <= '0;
      idx_reg       <= '0;
      gap_reg       <= '0;
      hist_reg      <= '0;
      fill_reg      <= '0;
      run_cnt_reg   <= '0;
      match_cnt_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= shreg_next;
      idx_reg       <= idx_next;
      gap_reg       <= gap_next;
      hist_reg      <= hist_next;
      fill_reg      <= fill_next;
      run_cnt_reg   <= run_cnt_next;
      match_cnt_reg <= match_cnt_next;
      done_reg      <= done_next;
    end
  end

  assign o_ready     = ready;
  assign o_a         = a_bit;
  assign o_a_valid   = a_valid;
  assign o_last      = last_bit;
  assign o_exp_match = exp_match;
  assign o_done      = done_reg;
  assign o_match_cnt = match_cnt_reg;

endmodule
